ser576to72: RTL and testbench

SER576TO72 -- requirements
Module: ser576to72

---
 rtl/ser_pkg.sv | 26 ++
 rtl/ser8to1.sv | 54 +++++
 rtl/ser576to72.sv | 215 +++++++++++++++++++++
 tb/tb_ser576to72.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// ser_pkg -- shared constants and types for the 576-to-72 serializer.
// Frame geometry (lanes, phases, words per frame), the 3-bit phase type
// and the frame-source selector used when a new frame is loaded.
package ser_pkg;

   localparam int LANES       = 8;
   localparam int PHASES      = 8;
   localparam int FRAME_WORDS = 64;

   typedef logic [2:0] phase_t;

   localparam phase_t PHASE_LAST = 3'd7;

   // Where the frame register takes its next contents from on the last phase.
   typedef enum logic [1:0] {
      SRC_IDLE   = 2'd0,
      SRC_BUF    = 2'd1,
      SRC_BYPASS = 2'd2
   } src_sel_e;

   // Phase counter successor; wraps naturally from 7 to 0.
   function automatic phase_t phase_inc(input phase_t p);
      return p + 3'd1;
   endfunction

endpackage

// File: rtl/ser8to1.sv
// ser8to1 -- one serial lane.
// Holds the 8 words of the current frame that belong to this lane and
// registers the word for the upcoming phase onto lane_q every clock.
// On a load edge the new frame's first word goes straight to lane_q so the
// lane shows word 0 in the very next cycle.
module ser8to1
   import ser_pkg::*;
#(
   parameter int              W         = 9,
   parameter logic [W-1:0]    IDLE_WORD = {W{1'b0}}
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  phase_t              phi,
   input  logic [PHASES*W-1:0] load_words,
   output logic [W-1:0]        lane_q
);

   logic [W-1:0] word_r [PHASES];
   phase_t       sel_s;
   logic [W-1:0] next_word_s;

   // Pick the word to present in the next phase: new frame word 0 on load,
   // otherwise the held word for phi + 1.
   always_comb begin
      sel_s       = phase_inc(phi);
      next_word_s = word_r[sel_s];
      if (load) begin
         next_word_s = load_words[W-1:0];
      end else begin
         next_word_s = word_r[sel_s];
      end
   end

   // Word storage for this lane plus the registered lane output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < PHASES; j++) begin
            word_r[j] <= IDLE_WORD;
         end
         lane_q <= IDLE_WORD;
      end else begin
         if (load) begin
            for (int j = 0; j < PHASES; j++) begin
               word_r[j] <= load_words[j*W +: W];
            end
         end
         lane_q <= next_word_s;
      end
   end

endmodule

// File: rtl/ser576to72.sv
// ser576to72 -- 64-word frame to 8-lane serializer.
// A free-running 3-bit phase counter sequences 8 words per lane per frame.
// Frames are accepted into a one-frame holding buffer and moved into the
// lane registers on the last phase; with nothing available an idle frame is
// sent and a sticky underflow flag is raised.
// Optional build macro: SER_UNDERFLOW_CNT_EN adds a saturating 16-bit
// underflow event counter on port underflow_cnt.
module ser576to72
   import ser_pkg::*;
#(
   parameter int           W         = 9,
   parameter logic [W-1:0] IDLE_WORD = {W{1'b0}}
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [2:0]               phi_init,
   input  logic [FRAME_WORDS*W-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [W-1:0]             out_0,
   output logic [W-1:0]             out_1,
   output logic [W-1:0]             out_2,
   output logic [W-1:0]             out_3,
   output logic [W-1:0]             out_4,
   output logic [W-1:0]             out_5,
   output logic [W-1:0]             out_6,
   output logic [W-1:0]             out_7,
   output logic                     out_valid,
   output logic                     clkout_load,
   output logic                     clkout_dsp,
   output logic                     underflow,
   input  logic                     underflow_clr
`ifdef SER_UNDERFLOW_CNT_EN
   ,
   output logic [15:0]              underflow_cnt
`endif
);

   phase_t                   phi_r;
   phase_t                   phi_next_s;
   logic [FRAME_WORDS*W-1:0] buf_r;
   logic                     buf_full_r;
   logic                     out_valid_r;
   logic                     underflow_r;
   logic                     clkout_load_r;

   logic                     at_last_s;
   logic                     in_ready_s;
   logic                     accept_s;
   logic                     buf_write_s;
   logic                     uf_event_s;
   logic                     src_real_s;
   src_sel_e                 src_sel_s;
   logic [FRAME_WORDS*W-1:0] src_frame_s;

   logic [PHASES*W-1:0]      lane_words_s [LANES];
   logic [W-1:0]             lane_q_s     [LANES];

   // Handshake and frame-source decision. A frame accepted on the last
   // phase while the buffer is empty bypasses the buffer and goes straight
   // to the lanes, giving the one-cycle minimum latency.
   always_comb begin
      phi_next_s = phase_inc(phi_r);
      at_last_s  = (phi_r == PHASE_LAST);
      in_ready_s = !buf_full_r || at_last_s;
      accept_s   = in_valid && in_ready_s;
      src_sel_s  = SRC_IDLE;
      if (!at_last_s) begin
         src_sel_s = SRC_IDLE;
      end else if (buf_full_r) begin
         src_sel_s = SRC_BUF;
      end else if (accept_s) begin
         src_sel_s = SRC_BYPASS;
      end else begin
         src_sel_s = SRC_IDLE;
      end
      buf_write_s = accept_s && (src_sel_s != SRC_BYPASS);
      uf_event_s  = at_last_s && (src_sel_s == SRC_IDLE);
   end

   // Frame contents for the next load and whether it carries real data.
   always_comb begin
      src_frame_s = {FRAME_WORDS{IDLE_WORD}};
      src_real_s  = 1'b0;
      case (src_sel_s)
         SRC_BUF: begin
            src_frame_s = buf_r;
            src_real_s  = 1'b1;
         end
         SRC_BYPASS: begin
            src_frame_s = in_data;
            src_real_s  = 1'b1;
         end
         SRC_IDLE: begin
            src_frame_s = {FRAME_WORDS{IDLE_WORD}};
            src_real_s  = 1'b0;
         end
         default: begin
            src_frame_s = {FRAME_WORDS{IDLE_WORD}};
            src_real_s  = 1'b0;
         end
      endcase
   end

   // Scatter the frame across lanes: lane i gets words i, 8+i, ..., 56+i.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         lane_words_s[i] = {PHASES*W{1'b0}};
         for (int j = 0; j < PHASES; j++) begin
            lane_words_s[i][j*W +: W] = src_frame_s[(PHASES*j + i)*W +: W];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         ser8to1 #(
            .W         (W),
            .IDLE_WORD (IDLE_WORD)
         ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (at_last_s),
            .phi        (phi_r),
            .load_words (lane_words_s[gi]),
            .lane_q     (lane_q_s[gi])
         );
      end
   endgenerate

   // Free-running phase counter, preset from phi_init while in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phi_r <= phi_init;
      end else begin
         phi_r <= phi_next_s;
      end
   end

   // Divide-by-8 clock: high while the phase counter is in 4..7.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clkout_load_r <= phi_init[2];
      end else begin
         clkout_load_r <= phi_next_s[2];
      end
   end

   // One-frame holding buffer; a refill on the last phase keeps it full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_r      <= {FRAME_WORDS*W{1'b0}};
         buf_full_r <= 1'b0;
      end else if (buf_write_s) begin
         buf_r      <= in_data;
         buf_full_r <= 1'b1;
      end else if (at_last_s && buf_full_r) begin
         buf_full_r <= 1'b0;
      end
   end

   // Frame-valid flag, updated only when a new frame is loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
      end else if (at_last_s) begin
         out_valid_r <= src_real_s;
      end
   end

   // Sticky underflow flag; a clear wins over a simultaneous set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underflow_r <= 1'b0;
      end else if (underflow_clr) begin
         underflow_r <= 1'b0;
      end else if (uf_event_s) begin
         underflow_r <= 1'b1;
      end
   end

`ifdef SER_UNDERFLOW_CNT_EN
   logic [15:0] underflow_cnt_r;

   // Saturating count of underflow events, cleared with the flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underflow_cnt_r <= 16'd0;
      end else if (underflow_clr) begin
         underflow_cnt_r <= 16'd0;
      end else if (uf_event_s && (underflow_cnt_r != 16'hFFFF)) begin
         underflow_cnt_r <= underflow_cnt_r + 16'd1;
      end
   end

   assign underflow_cnt = underflow_cnt_r;
`endif

   assign in_ready    = in_ready_s;
   assign out_0       = lane_q_s[0];
   assign out_1       = lane_q_s[1];
   assign out_2       = lane_q_s[2];
   assign out_3       = lane_q_s[3];
   assign out_4       = lane_q_s[4];
   assign out_5       = lane_q_s[5];
   assign out_6       = lane_q_s[6];
   assign out_7       = lane_q_s[7];
   assign out_valid   = out_valid_r;
   assign underflow   = underflow_r;
   assign clkout_load = clkout_load_r;
   assign clkout_dsp  = !clkout_load_r;

endmodule

// File: tb/tb_ser576to72.sv
// tb_ser576to72 -- directed self-checking bench for ser576to72.
// Inputs change 1 time unit after the rising edge and outputs are sampled
// there; the bench tracks the phase with its own counter.
module tb_ser576to72;

   localparam logic [8:0] IDLE = 9'h1A5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [2:0]   phi_init;
   logic [575:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [8:0]   out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7;
   logic         out_valid;
   logic         clkout_load;
   logic         clkout_dsp;
   logic         underflow;
   logic         underflow_clr;
`ifdef SER_UNDERFLOW_CNT_EN
   logic [15:0]  underflow_cnt;
`endif

   logic [8:0]   lane_s [8];
   logic [2:0]   tb_phi;
   int           checks = 0;
   int           errors = 0;

   ser576to72 #(.W(9), .IDLE_WORD(IDLE)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .phi_init      (phi_init),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .out_0         (out_0),
      .out_1         (out_1),
      .out_2         (out_2),
      .out_3         (out_3),
      .out_4         (out_4),
      .out_5         (out_5),
      .out_6         (out_6),
      .out_7         (out_7),
      .out_valid     (out_valid),
      .clkout_load   (clkout_load),
      .clkout_dsp    (clkout_dsp),
      .underflow     (underflow),
      .underflow_clr (underflow_clr)
`ifdef SER_UNDERFLOW_CNT_EN
      ,
      .underflow_cnt (underflow_cnt)
`endif
   );

   always #5 clk = ~clk;

   assign lane_s[0] = out_0;
   assign lane_s[1] = out_1;
   assign lane_s[2] = out_2;
   assign lane_s[3] = out_3;
   assign lane_s[4] = out_4;
   assign lane_s[5] = out_5;
   assign lane_s[6] = out_6;
   assign lane_s[7] = out_7;

   // Reference phase: preset while in reset, +1 every edge otherwise.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_phi <= phi_init;
      else        tb_phi <= tb_phi + 3'd1;
   end

   function automatic logic [575:0] mk_frame(input int base);
      logic [575:0] f;
      f = '0;
      for (int k = 0; k < 64; k++) f[k*9 +: 9] = 9'((base + k) % 512);
      return f;
   endfunction

   function automatic logic [8:0] exp_word(input int base, input int k);
      return 9'((base + k) % 512);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_to_phi(input int p);
      int n;
      n = 0;
      while (tb_phi != 3'(p) && n < 16) begin
         step();
         n++;
      end
   endtask

   task automatic pulse_clr();
      underflow_clr = 1'b1;
      step();
      underflow_clr = 1'b0;
   endtask

   task automatic test_reset();
      phi_init = 3'd0; in_valid = 1'b0; in_data = '0; underflow_clr = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      step(); step();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (lane_s[i] !== IDLE) begin
            errors++; $display("FAIL reset_lane%0d got %h want %h", i, lane_s[i], IDLE);
         end
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b want 0", underflow); end
      checks++; if (clkout_load !== 1'b0) begin errors++; $display("FAIL reset_clkout_load got %b want 0", clkout_load); end
      checks++; if (clkout_dsp !== 1'b1) begin errors++; $display("FAIL reset_clkout_dsp got %b want 1", clkout_dsp); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_underflow();
      go_to_phi(7);
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_before got %b want 0", underflow); end
      step();
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set got %b want 1", underflow); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL uf_out_valid got %b want 0", out_valid); end
      checks++; if (out_3 !== IDLE) begin errors++; $display("FAIL uf_lane3 got %h want %h", out_3, IDLE); end
      pulse_clr();
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clr got %b want 0", underflow); end
   endtask

   task automatic test_single_frame();
      go_to_phi(3);
      in_valid = 1'b1; in_data = mk_frame(0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sf_ready_p3 got %b want 1", in_ready); end
      step();
      in_valid = 1'b0; in_data = '0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sf_ready_p4 got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sf_early_valid got %b want 0", out_valid); end
      go_to_phi(7);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sf_ready_p7 got %b want 1", in_ready); end
      step();
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (lane_s[i] !== exp_word(0, 8*p + i)) begin
               errors++; $display("FAIL sf_p%0d_lane%0d got %h want %h", p, i, lane_s[i], exp_word(0, 8*p + i));
            end
         end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sf_valid_p%0d got %b want 1", p, out_valid); end
         checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL sf_uf_p%0d got %b want 0", p, underflow); end
         checks++; if (clkout_load !== (p >= 4)) begin errors++; $display("FAIL sf_clkload_p%0d got %b want %b", p, clkout_load, (p >= 4)); end
         checks++; if (clkout_dsp !== (p < 4)) begin errors++; $display("FAIL sf_clkdsp_p%0d got %b want %b", p, clkout_dsp, (p < 4)); end
         step();
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sf_after_valid got %b want 0", out_valid); end
      checks++; if (out_0 !== IDLE) begin errors++; $display("FAIL sf_after_lane0 got %h want %h", out_0, IDLE); end
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL sf_after_uf got %b want 1", underflow); end
      pulse_clr();
   endtask

   task automatic test_back_to_back();
      int bases [4];
      bases = '{100, 200, 300, 400};
      go_to_phi(1);
      in_valid = 1'b1; in_data = mk_frame(bases[0]);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got %b want 1", in_ready); end
      step();
      in_data = mk_frame(bases[1]);
      while (tb_phi != 3'd7) begin
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_wait_ready phi%0d got %b want 0", tb_phi, in_ready); end
         step();
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_wait_ready7 got %b want 1", in_ready); end
      step();
      in_data = mk_frame(bases[2]);
      for (int f = 0; f < 4; f++) begin
         for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 8; i++) begin
               checks++;
               if (lane_s[i] !== exp_word(bases[f], 8*p + i)) begin
                  errors++; $display("FAIL b2b_f%0d_p%0d_lane%0d got %h want %h", f, p, i, lane_s[i], exp_word(bases[f], 8*p + i));
               end
            end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_f%0d_p%0d got %b want 1", f, p, out_valid); end
            checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL b2b_uf_f%0d_p%0d got %b want 0", f, p, underflow); end
            checks++;
            if (in_ready !== ((p == 7) || (f == 3))) begin
               errors++; $display("FAIL b2b_ready_f%0d_p%0d got %b want %b", f, p, in_ready, ((p == 7) || (f == 3)));
            end
            step();
         end
         if (f == 0) in_data = mk_frame(bases[3]);
         if (f == 1) begin in_valid = 1'b0; in_data = '0; end
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b want 0", out_valid); end
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL b2b_end_uf got %b want 1", underflow); end
      pulse_clr();
   endtask

   task automatic test_bypass();
      go_to_phi(7);
      in_valid = 1'b1; in_data = mk_frame(50);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL byp_ready got %b want 1", in_ready); end
      step();
      in_valid = 1'b0; in_data = '0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (lane_s[i] !== exp_word(50, i)) begin
            errors++; $display("FAIL byp_lane%0d got %h want %h", i, lane_s[i], exp_word(50, i));
         end
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL byp_valid got %b want 1", out_valid); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL byp_uf got %b want 0", underflow); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL byp_buf_empty got %b want 1", in_ready); end
   endtask

   task automatic test_clr_priority();
      go_to_phi(7);
      underflow_clr = 1'b1;
      step();
      underflow_clr = 1'b0;
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL clrprio_uf got %b want 0", underflow); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clrprio_valid got %b want 0", out_valid); end
      go_to_phi(7);
      step();
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL clrprio_reset got %b want 1", underflow); end
      pulse_clr();
   endtask

   task automatic test_mid_reset();
      go_to_phi(7);
      in_valid = 1'b1; in_data = mk_frame(300);
      step();
      in_valid = 1'b0; in_data = '0;
      go_to_phi(4);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mr_pre_valid got %b want 1", out_valid); end
      checks++; if (out_0 !== exp_word(300, 32)) begin errors++; $display("FAIL mr_pre_lane0 got %h want %h", out_0, exp_word(300, 32)); end
      phi_init = 3'd5;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (lane_s[i] !== IDLE) begin errors++; $display("FAIL mr_lane%0d got %h want %h", i, lane_s[i], IDLE); end
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b want 0", out_valid); end
      checks++; if (clkout_load !== 1'b1) begin errors++; $display("FAIL mr_clkload got %b want 1", clkout_load); end
      checks++; if (clkout_dsp !== 1'b0) begin errors++; $display("FAIL mr_clkdsp got %b want 0", clkout_dsp); end
      step(); step();
      checks++; if (clkout_load !== 1'b1) begin errors++; $display("FAIL mr_hold_clkload got %b want 1", clkout_load); end
      rst_n = 1'b1;
      step();
      checks++; if (clkout_load !== 1'b1) begin errors++; $display("FAIL mr_phi6_clkload got %b want 1", clkout_load); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL mr_phi6_uf got %b want 0", underflow); end
      step();
      checks++; if (clkout_load !== 1'b1) begin errors++; $display("FAIL mr_phi7_clkload got %b want 1", clkout_load); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL mr_phi7_uf got %b want 0", underflow); end
      step();
      checks++; if (clkout_load !== 1'b0) begin errors++; $display("FAIL mr_phi0_clkload got %b want 0", clkout_load); end
      checks++; if (clkout_dsp !== 1'b1) begin errors++; $display("FAIL mr_phi0_clkdsp got %b want 1", clkout_dsp); end
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL mr_phi0_uf got %b want 1", underflow); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_phi0_valid got %b want 0", out_valid); end
      pulse_clr();
   endtask

`ifdef SER_UNDERFLOW_CNT_EN
   task automatic test_underflow_cnt();
      pulse_clr();
      checks++; if (underflow_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clr got %h want 0000", underflow_cnt); end
      repeat (24) step();
      checks++; if (underflow_cnt !== 16'd3) begin errors++; $display("FAIL cnt_three got %h want 0003", underflow_cnt); end
      repeat (65536 * 8) step();
      checks++; if (underflow_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat got %h want ffff", underflow_cnt); end
      pulse_clr();
      checks++; if (underflow_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clr2 got %h want 0000", underflow_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_underflow();
      test_single_frame();
      test_back_to_back();
      test_bypass();
      test_clr_priority();
      test_mid_reset();
`ifdef SER_UNDERFLOW_CNT_EN
      test_underflow_cnt();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
